// File: rtl/gray_count_sequencer.sv
// gray_count_sequencer: issues a job of Gray-coded counts over valid/ready.
// Optional self-check: define GRAY_COUNT_SEQUENCER_CHECK_EN.
module gray_count_sequencer #(
    parameter  int WIDTH = 4,
    localparam int LEN_W = WIDTH + 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] start_value,
    input  logic [LEN_W-1:0] start_length,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gray,
    output logic [WIDTH-1:0] out_binary,
    output logic             out_last,
    output logic             done,
    output logic             check_error
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_binary_q, out_binary_d;
    logic [WIDTH-1:0] out_gray_q, out_gray_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             done_q, done_d;
    logic             start_ready_q, start_ready_d;

    logic             beat;
    logic [WIDTH-1:0] bin_inc;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign beat    = out_valid_q & out_ready;
    assign bin_inc = out_binary_q + WIDTH'(1);

    // Next-state and next-output logic for the IDLE/RUN/DONE job sequencer
    always_comb begin
        state_d       = state_q;
        out_binary_d  = out_binary_q;
        out_gray_d    = out_gray_q;
        remaining_d   = remaining_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        done_d        = 1'b0;
        start_ready_d = start_ready_q;
        unique case (state_q)
            IDLE: begin
                start_ready_d = 1'b1;
                if (start_valid) begin
                    out_binary_d  = start_value;
                    out_gray_d    = to_gray(start_value);
                    remaining_d   = start_length;
                    start_ready_d = 1'b0;
                    if (start_length == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = RUN;
                        out_valid_d = 1'b1;
                        out_last_d  = (start_length == LEN_W'(1));
                    end
                end
            end
            RUN: begin
                if (beat) begin
                    out_binary_d = bin_inc;
                    out_gray_d   = to_gray(bin_inc);
                    remaining_d  = remaining_q - LEN_W'(1);
                    out_last_d   = (remaining_q == LEN_W'(2));
                    if (out_last_q || abort) begin
                        state_d     = DONE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                    end
                end else if (abort) begin
                    state_d     = DONE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                end
            end
            DONE: begin
                state_d       = IDLE;
                start_ready_d = 1'b1;
            end
            default: begin
                state_d       = IDLE;
                out_valid_d   = 1'b0;
                out_last_d    = 1'b0;
                start_ready_d = 1'b1;
            end
        endcase
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            out_binary_q  <= '0;
            out_gray_q    <= '0;
            remaining_q   <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            done_q        <= 1'b0;
            start_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            out_binary_q  <= out_binary_d;
            out_gray_q    <= out_gray_d;
            remaining_q   <= remaining_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            done_q        <= done_d;
            start_ready_q <= start_ready_d;
        end
    end

    assign start_ready = start_ready_q;
    assign out_valid   = out_valid_q;
    assign out_gray    = out_gray_q;
    assign out_binary  = out_binary_q;
    assign out_last    = out_last_q;
    assign done        = done_q;

`ifdef GRAY_COUNT_SEQUENCER_CHECK_EN
    logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
    logic             seen_q, seen_d;
    logic             check_error_q, check_error_d;
    logic [WIDTH-1:0] gray_diff;

    function automatic logic [WIDTH-1:0] to_binary(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign gray_diff = out_gray_q ^ prev_gray_q;

    // Decode-back and one-bit-step checks on every delivered beat
    always_comb begin
        prev_gray_d   = prev_gray_q;
        seen_d        = seen_q;
        check_error_d = check_error_q;
        if (state_q == IDLE && start_valid) begin
            seen_d = 1'b0;
        end
        if (beat) begin
            prev_gray_d = out_gray_q;
            seen_d      = 1'b1;
            if (to_binary(out_gray_q) != out_binary_q) begin
                check_error_d = 1'b1;
            end
            if (seen_q && ((gray_diff == '0) ||
                ((gray_diff & (gray_diff - WIDTH'(1))) != '0))) begin
                check_error_d = 1'b1;
            end
        end
    end

    // Checker history and sticky error flag
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prev_gray_q   <= '0;
            seen_q        <= 1'b0;
            check_error_q <= 1'b0;
        end else begin
            prev_gray_q   <= prev_gray_d;
            seen_q        <= seen_d;
            check_error_q <= check_error_d;
        end
    end

    assign check_error = check_error_q;
`else
    assign check_error = 1'b0;
`endif

endmodule
